// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default constants for the unified memory-port arbiter.
//   state_t : arbiter FSM states (IDLE, WAIT, RESP)
//   owner_t : which requester owns the current access (OWN_IF=0, OWN_D=1)
//   DEF_*   : default parameter values for the arbiter and its wait counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 255;

    // MAX_WAIT is limited to 1..255, so eight bits always hold the count.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// -----------------------------------------------------------------------------
// arb_wait_counter
// Counts the cycles an access has spent waiting for the memory acknowledge.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low reset
//   clr_i     : synchronous clear (has priority over en_i)
//   en_i      : count this cycle
//   expired_o : high during the MAX_WAIT-th counted cycle and beyond
// The count is zero-based: it reads 0 in the first wait cycle, so the
// MAX_WAIT-th cycle is the one where it reads MAX_WAIT-1. It saturates there,
// so expired_o stays high if enable is held.
// -----------------------------------------------------------------------------
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one multi-cycle memory port between instruction fetch (IF) and
// data load/store (MEM). Each access is a req/ack handshake on the memory
// side and a one-cycle ready pulse back to the owning requester.
//
// Ports
//   clk_i, rst_i                  : clock; asynchronous active-low reset
//   if_req_i, if_addr_i           : fetch request and address (held to ready)
//   if_ready_o, if_rdata_o        : fetch done pulse; instruction (held)
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                     : data request, store flag, address, data
//   d_ready_o, d_rdata_o          : data done pulse; load data (held)
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o       : memory request and registered payload
//   mem_ack_i, mem_rdata_i        : memory done; read data same cycle
//   stall_o                       : a requester is still waiting (combinational)
//   err_o                         : sticky flag, set when an access times out
//
// Configuration macro
//   ARB_RR_EN : when defined, simultaneous requests alternate (round robin)
//               based on the last grant; otherwise data always beats fetch,
//               since the load/store belongs to the older instruction.
//
// Access timing: request seen in IDLE at t, mem_req_o from t+1, ack at
// t+1+k, ready pulse at t+2+k. An access with no ack for MAX_WAIT cycles
// completes anyway with zero read data and sets err_o.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT   // legal range 1..255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ready_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              err_o
);

    state_t            state_q, state_d;
    owner_t            owner_q, grant_owner;
    logic              any_req;
    logic              capture;
    logic              timeout;
    logic              cnt_expired;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              err_q;

    assign any_req = if_req_i | d_req_i;

    // ------------------------------------------------------------------
    // Arbitration pick (only acted on in IDLE)
    // ------------------------------------------------------------------
`ifdef ARB_RR_EN
    owner_t last_grant_q;

    always_comb begin
        if (if_req_i && d_req_i) begin
            grant_owner = (last_grant_q == OWN_D) ? OWN_IF : OWN_D;
        end else begin
            grant_owner = d_req_i ? OWN_D : OWN_IF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant_q <= OWN_IF;
        end else if ((state_q == IDLE) && any_req) begin
            last_grant_q <= grant_owner;
        end
    end
`else
    always_comb begin
        grant_owner = d_req_i ? OWN_D : OWN_IF;
    end
`endif

    // ------------------------------------------------------------------
    // Wait counter: runs only while WAIT, cleared in every other state
    // ------------------------------------------------------------------
    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q != WAIT),
        .en_i      (state_q == WAIT),
        .expired_o (cnt_expired)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        timeout    = 1'b0;
        mem_req_o  = 1'b0;
        if_ready_o = 1'b0;
        d_ready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_req_o = 1'b1;
                // An ack in the expiry cycle still wins over the timeout.
                if (mem_ack_i) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (cnt_expired) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if_ready_o = (owner_q == OWN_IF);
                d_ready_o  = (owner_q == OWN_D);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Access payload, read data and error flag
    // ------------------------------------------------------------------
    // NOTE: these are registers in a small control block, so all of them
    // are reset; nothing here is a memory array that would be left unreset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if ((state_q == IDLE) && any_req) begin
                owner_q <= grant_owner;
                if (grant_owner == OWN_D) begin
                    addr_q  <= d_addr_i;
                    we_q    <= d_we_i;
                    wdata_q <= d_wdata_i;
                end else begin
                    addr_q  <= if_addr_i;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end
            end

            if (capture) begin
                if (owner_q == OWN_D) begin
                    d_rdata_q <= mem_rdata_i;
                end else begin
                    if_rdata_q <= mem_rdata_i;
                end
            end else if (timeout) begin
                err_q <= 1'b1;
                if (owner_q == OWN_D) begin
                    d_rdata_q <= '0;
                end else begin
                    if_rdata_q <= '0;
                end
            end
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;
    assign stall_o     = (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter built with MAX_WAIT=4. Inputs change
// 1 ns after a rising edge; outputs are sampled at that point (registered)
// or 1 ns later after an input change (combinational stall_o).
// Expected values for simultaneous requests follow ARB_RR_EN if defined.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_ready_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_req_i = 1'b0;
    logic          d_we_i = 1'b0;
    logic [AW-1:0] d_addr_i = '0;
    logic [DW-1:0] d_wdata_i = '0;
    logic          d_ready_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          stall_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ready_o  (if_ready_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_ready_o   (d_ready_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("rst_mem_req",   32'(mem_req_o),   32'h0);
        check("rst_mem_we",    32'(mem_we_o),    32'h0);
        check("rst_mem_addr",  mem_addr_o,       32'h0);
        check("rst_mem_wdata", mem_wdata_o,      32'h0);
        check("rst_if_ready",  32'(if_ready_o),  32'h0);
        check("rst_d_ready",   32'(d_ready_o),   32'h0);
        check("rst_if_rdata",  if_rdata_o,       32'h0);
        check("rst_d_rdata",   d_rdata_o,        32'h0);
        check("rst_err",       32'(err_o),       32'h0);
        check("rst_stall",     32'(stall_o),     32'h0);
        tick();
        rst_i = 1'b1;
        tick();
        check("idle_mem_req", 32'(mem_req_o), 32'h0);

        // ---------------- ack outside WAIT is ignored ----------------
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        tick();
        check("stray_ack_if_ready", 32'(if_ready_o), 32'h0);
        check("stray_ack_d_ready",  32'(d_ready_o),  32'h0);
        check("stray_ack_mem_req",  32'(mem_req_o),  32'h0);
        check("stray_ack_if_rdata", if_rdata_o,      32'h0);
        mem_ack_i = 1'b0;

        // ---------------- single fetch, ack 2 cycles after mem_req ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        settle();
        check("f1_stall_idle", 32'(stall_o),   32'h1);
        check("f1_req_idle",   32'(mem_req_o), 32'h0);
        tick();
        check("f1_mem_req",  32'(mem_req_o), 32'h1);
        check("f1_mem_addr", mem_addr_o,     32'h10);
        check("f1_mem_we",   32'(mem_we_o),  32'h0);
        check("f1_stall",    32'(stall_o),   32'h1);
        tick();
        check("f1_mem_req_w1", 32'(mem_req_o), 32'h1);
        tick();
        check("f1_mem_req_w2", 32'(mem_req_o), 32'h1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0050_0093;
        tick();
        check("f1_if_ready",   32'(if_ready_o), 32'h1);
        check("f1_if_rdata",   if_rdata_o,      32'h0050_0093);
        check("f1_req_resp",   32'(mem_req_o),  32'h0);
        check("f1_stall_resp", 32'(stall_o),    32'h0);
        mem_ack_i = 1'b0;
        if_req_i  = 1'b0;
        tick();
        check("f1_ready_gone", 32'(if_ready_o), 32'h0);
        check("f1_rdata_held", if_rdata_o,      32'h0050_0093);

        // ---------------- simultaneous requests, data first ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h20;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h80;
        tick();
        check("s1_first_addr", mem_addr_o,    32'h80);
        check("s1_first_we",   32'(mem_we_o), 32'h0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        tick();
        check("s1_d_ready",  32'(d_ready_o),  32'h1);
        check("s1_if_ready", 32'(if_ready_o), 32'h0);
        check("s1_d_rdata",  d_rdata_o,       32'h1111_2222);
        mem_ack_i = 1'b0;
        d_req_i   = 1'b0;
        settle();
        check("s1_stall_if_waiting", 32'(stall_o), 32'h1);
        tick();
        check("s1_idle_gap", 32'(mem_req_o), 32'h0);
        check("s1_d_pulse",  32'(d_ready_o), 32'h0);
        tick();
        check("s1_second_req",  32'(mem_req_o), 32'h1);
        check("s1_second_addr", mem_addr_o,     32'h20);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h3333_4444;
        tick();
        check("s1_if_ready2", 32'(if_ready_o), 32'h1);
        check("s1_if_rdata2", if_rdata_o,      32'h3333_4444);
        check("s1_d_held",    d_rdata_o,       32'h1111_2222);
        mem_ack_i = 1'b0;
        if_req_i  = 1'b0;
        tick();

        // ---------------- store, payload changes during WAIT ----------------
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h40;
        d_wdata_i = 32'hDEAD_BEEF;
        tick();
        check("st_mem_req",   32'(mem_req_o), 32'h1);
        check("st_mem_we",    32'(mem_we_o),  32'h1);
        check("st_mem_addr",  mem_addr_o,     32'h40);
        check("st_mem_wdata", mem_wdata_o,    32'hDEAD_BEEF);
        d_wdata_i = 32'h0;
        d_addr_i  = 32'h44;
        tick();
        check("st_wdata_stable", mem_wdata_o,    32'hDEAD_BEEF);
        check("st_addr_stable",  mem_addr_o,     32'h40);
        check("st_we_stable",    32'(mem_we_o),  32'h1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_AAAA;
        tick();
        check("st_d_ready", 32'(d_ready_o), 32'h1);
        check("st_req_off", 32'(mem_req_o), 32'h0);
        mem_ack_i = 1'b0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        tick();
        check("st_single_pulse", 32'(d_ready_o), 32'h0);

        // ---------------- simultaneous requests after a data grant ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h20;
        d_req_i   = 1'b1;
        d_addr_i  = 32'h84;
        tick();
        check("s2_first_addr", mem_addr_o, RR ? 32'h20 : 32'h84);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h600D_0001;
        tick();
        check("s2_first_if_ready", 32'(if_ready_o), RR ? 32'h1 : 32'h0);
        check("s2_first_d_ready",  32'(d_ready_o),  RR ? 32'h0 : 32'h1);
        mem_ack_i = 1'b0;
        if (RR) if_req_i = 1'b0;
        else    d_req_i  = 1'b0;
        tick();
        tick();
        check("s2_second_addr", mem_addr_o, RR ? 32'h84 : 32'h20);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h600D_0002;
        tick();
        check("s2_second_if_ready", 32'(if_ready_o), RR ? 32'h0 : 32'h1);
        check("s2_second_d_ready",  32'(d_ready_o),  RR ? 32'h1 : 32'h0);
        mem_ack_i = 1'b0;
        if_req_i  = 1'b0;
        d_req_i   = 1'b0;
        tick();

        // ---------------- ack in the MAX_WAIT-th cycle is a normal ack ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h30;
        tick();
        tick();
        tick();
        tick();
        check("edge_req_4th", 32'(mem_req_o), 32'h1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0000_0077;
        tick();
        check("edge_if_ready", 32'(if_ready_o), 32'h1);
        check("edge_if_rdata", if_rdata_o,      32'h0000_0077);
        check("edge_no_err",   32'(err_o),      32'h0);
        mem_ack_i = 1'b0;
        if_req_i  = 1'b0;
        tick();

        // ---------------- timeout, request dropped mid-access ----------------
        d_req_i  = 1'b1;
        d_addr_i = 32'h90;
        tick();
        check("to_mem_req1", 32'(mem_req_o), 32'h1);
        check("to_mem_addr", mem_addr_o,     32'h90);
        tick();
        d_req_i = 1'b0;
        tick();
        tick();
        check("to_mem_req4", 32'(mem_req_o), 32'h1);
        check("to_err_pre",  32'(err_o),     32'h0);
        tick();
        check("to_mem_req_off", 32'(mem_req_o),  32'h0);
        check("to_d_ready",     32'(d_ready_o),  32'h1);
        check("to_d_rdata",     d_rdata_o,       32'h0);
        check("to_err",         32'(err_o),      32'h1);
        check("to_if_ready",    32'(if_ready_o), 32'h0);
        tick();
        check("to_d_pulse",  32'(d_ready_o), 32'h0);
        check("to_err_sticky", 32'(err_o),   32'h1);

        // ---------------- reset in the middle of an access ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h50;
        tick();
        check("mr_req_before", 32'(mem_req_o), 32'h1);
        tick();
        rst_i = 1'b0;
        settle();
        check("mr_req_drop",  32'(mem_req_o),  32'h0);
        check("mr_err_clear", 32'(err_o),      32'h0);
        check("mr_if_ready",  32'(if_ready_o), 32'h0);
        check("mr_addr_clear", mem_addr_o,     32'h0);
        tick();
        check("mr_no_ready", 32'(if_ready_o), 32'h0);
        rst_i = 1'b1;
        tick();
        check("mr_restart_req",  32'(mem_req_o), 32'h1);
        check("mr_restart_addr", mem_addr_o,     32'h50);
        check("mr_restart_rdy",  32'(if_ready_o), 32'h0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0000_0099;
        tick();
        check("mr_if_ready", 32'(if_ready_o), 32'h1);
        check("mr_if_rdata", if_rdata_o,      32'h0000_0099);
        mem_ack_i = 1'b0;
        if_req_i  = 1'b0;
        settle();
        check("mr_stall_end", 32'(stall_o), 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle unified memory port between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage pipelined CPU.
- Sequences each access with a req/ack handshake and returns read data to the owning requester.
- Drives a stall output that the hazard logic ORs into the PC-write and pipeline-register stall controls.

Parameters:
- ADDR_W, 32, address width of requesters and memory port.
- DATA_W, 32, data width.
- MAX_WAIT, 255, cycles to wait for mem_ack_i before forcing a timeout completion; 1..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held with if_addr_i until if_ready_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_ready_o  out  1  one-cycle pulse: fetch complete.
- if_rdata_o  out  DATA_W  fetched instruction; valid while if_ready_o=1, held afterwards.
- d_req_i  in  1  data request; held with d_we_i, d_addr_i and d_wdata_i until d_ready_o.
- d_we_i  in  1  1=store, 0=load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_ready_o  out  1  one-cycle pulse: data access complete.
- d_rdata_o  out  DATA_W  load data; valid while d_ready_o=1, held afterwards.
- mem_req_o  out  1  memory request; held until mem_ack_i.
- mem_we_o  out  1  write enable to memory.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_ack_i  in  1  memory done; rdata valid the same cycle.
- mem_rdata_i  in  DATA_W  memory read data.
- stall_o  out  1  combinational: (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o).
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=0, asynchronous) sets:
  - state=IDLE.
  - All memory-port outputs, ready pulses and rdata registers to 0.
  - err_o=0, wait counter=0, last-grant=fetch.
  - Any in-flight access is abandoned: mem_req_o drops immediately; no ready pulse follows.
- IDLE:
  - Sample requests.
  - Both pending: data wins (older instruction).
  - On grant, register owner, addr, we and wdata; go to WAIT. A fetch grant forces mem_we_o=0.
  - No request: stay in IDLE.
- WAIT:
  - mem_req_o=1; memory-port payload is stable from registers.
  - Counter increments each cycle.
  - mem_ack_i=1: capture mem_rdata_i into the owner's rdata register (store: d_rdata_o captures mem_rdata_i, don't-care); go to RESP.
  - Counter reaches MAX_WAIT without ack: set err_o, load 0 into the owner's rdata; go to RESP.
  - Ack on the MAX_WAIT cycle counts as a normal ack: err_o stays unchanged.
- RESP:
  - mem_req_o=0; the owner's ready_o=1 for exactly this cycle; counter clears; go to IDLE.
  - Requests are not sampled in RESP.
- Latency: request seen in IDLE at cycle t; mem_req_o at t+1; ack at t+1+k; ready at t+2+k. Minimum 3 cycles (k=0).
- mem_ack_i outside WAIT is ignored.
- A request still high in the IDLE cycle after RESP is treated as a new access.
- Requester payload changes during WAIT have no effect (registered).
- Request dropped before ready: the access still completes on the memory side; the ready pulse is still issued.
- Address passes through unmodified; no alignment check.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration.
  - When both requests are pending in IDLE, grant the requester not granted last.
  - Last-grant register updates on every grant.
- ARB_RR_EN undefined: fixed data-over-fetch priority; last-grant register absent.

Decomposition:
- Package mem_arb_pkg:
  - State encoding IDLE/WAIT/RESP.
  - Owner encoding OWN_IF=0, OWN_D=1.
  - Default ADDR_W/DATA_W/MAX_WAIT constants.
- Sub-module arb_wait_counter: clear/enable inputs, saturating counter, expiry flag at MAX_WAIT.
- Arbitration pick and FSM stay in the top module.

Test Plan:
- Single fetch:
  - Stimulus: if_req_i=1, if_addr_i=0x10; memory acks 2 cycles after mem_req_o rises with rdata 0x00500093.
  - Response: mem_addr_o=0x10, mem_we_o=0; if_ready_o pulses 1 cycle with if_rdata_o=0x00500093; stall_o=1 until that pulse.
- Simultaneous requests, fixed priority:
  - Stimulus: if_req_i=1 (0x20) and d_req_i=1 load (0x80) in the same cycle.
  - Response: first mem_addr_o=0x80; d_ready_o pulses before the fetch is granted; the fetch is then issued at 0x20.
- Same stimulus with ARB_RR_EN and last grant=data:
  - Response: fetch at 0x20 is granted first.
- Store:
  - Stimulus: d_we_i=1, d_addr_i=0x40, d_wdata_i=0xDEADBEEF.
  - Response: mem_we_o=1, mem_wdata_o=0xDEADBEEF held until ack; d_ready_o pulses once.
- Timeout:
  - Stimulus: MAX_WAIT=4; memory never acks.
  - Response: mem_req_o high 4 cycles, then owner ready pulses with rdata=0; err_o=1 and stays 1.
- Mid-access reset:
  - Stimulus: assert rst_i=0 while in WAIT.
  - Response: mem_req_o=0 immediately; no ready pulse; after release the next request starts cleanly from IDLE.
